// File: rtl/cobs_serial_rx.sv
// rtl/cobs_serial_rx.sv - 8N1 UART receiver, raw-byte FIFO and streaming COBS decoder
// Optional frame-error pulse output enabled by `define COBS_RX_FRAME_ERR_EN.
module cobs_serial_rx #(
   parameter int CLKS_PER_BIT = 234,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       busy,
   output logic       rx_flag,
   output logic [7:0] rx_data,
   output logic       o_flag,
   output logic [7:0] o_data,
   output logic       ovf
`ifdef COBS_RX_FRAME_ERR_EN
   ,
   output logic       frame_err
`endif
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT_HIGH} uart_state_t;
   typedef enum logic [1:0] {D_WAIT_CODE, D_DATA, D_BLOCK_END} dec_state_t;

   logic          rxd_meta_q, rxd_sync_q;
   uart_state_t   u_state_q, u_state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          rx_flag_q, rx_flag_d;
   logic [7:0]    rx_data_q, rx_data_d;
`ifdef COBS_RX_FRAME_ERR_EN
   logic          frame_err_q, frame_err_d;
`endif

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic          fifo_full, fifo_empty, push, pop;
   logic [7:0]    pop_byte;

   dec_state_t    d_state_q, d_state_d;
   logic [7:0]    code_q, code_d, cnt_q, cnt_d;
   logic          o_flag_q, o_flag_d, o_flag_prev_q;
   logic [7:0]    o_data_q, o_data_d;
   logic          load_code;

   always_comb begin
      u_state_d = u_state_q;
      clk_cnt_d = clk_cnt_q + CW'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      rx_flag_d = 1'b0;
      rx_data_d = rx_data_q;
`ifdef COBS_RX_FRAME_ERR_EN
      frame_err_d = 1'b0;
`endif
      case (u_state_q)
         U_IDLE: begin
            clk_cnt_d = '0;
            if (!rxd_sync_q) u_state_d = U_START;
         end
         U_START: if (clk_cnt_q == HALF_END) begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
            u_state_d = rxd_sync_q ? U_IDLE : U_DATA;
         end
         U_DATA: if (clk_cnt_q == BIT_END) begin
            clk_cnt_d = '0;
            shift_d   = {rxd_sync_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) u_state_d = U_STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
         end
         U_STOP: if (clk_cnt_q == BIT_END) begin
            clk_cnt_d = '0;
            if (rxd_sync_q) begin
               rx_flag_d = 1'b1;
               rx_data_d = shift_q;
               u_state_d = U_IDLE;
            end else begin
`ifdef COBS_RX_FRAME_ERR_EN
               frame_err_d = 1'b1;
`endif
               u_state_d = U_WAIT_HIGH;
            end
         end
         U_WAIT_HIGH: begin
            clk_cnt_d = '0;
            if (rxd_sync_q) u_state_d = U_IDLE;
         end
         default: u_state_d = U_IDLE;
      endcase
   end

   // Pop gap guarantees a consumer raising busy one cycle after o_flag is honoured.
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = !fifo_empty && !busy && !o_flag_q && !o_flag_prev_q;
      push       = rx_flag_q && (!fifo_full || pop);
      ovf_d      = rx_flag_q && fifo_full && !pop;
      pop_byte   = fifo_mem[rd_ptr_q[AW-1:0]];
      wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
   end

   always_comb begin
      d_state_d = d_state_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      o_flag_d  = 1'b0;
      o_data_d  = o_data_q;
      load_code = 1'b0;
      if (pop) begin
         if (pop_byte == 8'h00) begin
            d_state_d = D_WAIT_CODE;
         end else begin
            case (d_state_q)
               D_DATA: begin
                  o_flag_d = 1'b1;
                  o_data_d = pop_byte;
                  cnt_d    = cnt_q - 8'd1;
                  if (cnt_q == 8'd1) d_state_d = D_BLOCK_END;
               end
               D_BLOCK_END: begin
                  if (code_q != 8'hFF) begin
                     o_flag_d = 1'b1;
                     o_data_d = 8'h00;
                  end
                  load_code = 1'b1;
               end
               default: load_code = 1'b1;
            endcase
         end
      end
      if (load_code) begin
         code_d    = pop_byte;
         cnt_d     = pop_byte - 8'd1;
         d_state_d = (pop_byte == 8'd1) ? D_BLOCK_END : D_DATA;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= rx_data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_meta_q    <= 1'b1;
         rxd_sync_q    <= 1'b1;
         u_state_q     <= U_IDLE;
         clk_cnt_q     <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         rx_flag_q     <= 1'b0;
         rx_data_q     <= '0;
`ifdef COBS_RX_FRAME_ERR_EN
         frame_err_q   <= 1'b0;
`endif
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ovf_q         <= 1'b0;
         d_state_q     <= D_WAIT_CODE;
         code_q        <= '0;
         cnt_q         <= '0;
         o_flag_q      <= 1'b0;
         o_flag_prev_q <= 1'b0;
         o_data_q      <= '0;
      end else begin
         rxd_meta_q    <= rxd;
         rxd_sync_q    <= rxd_meta_q;
         u_state_q     <= u_state_d;
         clk_cnt_q     <= clk_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         rx_flag_q     <= rx_flag_d;
         rx_data_q     <= rx_data_d;
`ifdef COBS_RX_FRAME_ERR_EN
         frame_err_q   <= frame_err_d;
`endif
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ovf_q         <= ovf_d;
         d_state_q     <= d_state_d;
         code_q        <= code_d;
         cnt_q         <= cnt_d;
         o_flag_q      <= o_flag_d;
         o_flag_prev_q <= o_flag_q;
         o_data_q      <= o_data_d;
      end
   end

   assign rx_flag = rx_flag_q;
   assign rx_data = rx_data_q;
   assign o_flag  = o_flag_q;
   assign o_data  = o_data_q;
   assign ovf     = ovf_q;
`ifdef COBS_RX_FRAME_ERR_EN
   assign frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_cobs_serial_rx.sv
// tb/tb_cobs_serial_rx.sv - self-checking bench for cobs_serial_rx
// Expected decode comes from a frame-splitting COBS model over the bytes actually pushed.
module tb_cobs_serial_rx;
   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic       busy = 1'b0;
   logic       rx_flag, o_flag, ovf;
   logic [7:0] rx_data, o_data;
`ifdef COBS_RX_FRAME_ERR_EN
   logic       frame_err;
`endif

   cobs_serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .busy(busy),
      .rx_flag(rx_flag), .rx_data(rx_data),
      .o_flag(o_flag), .o_data(o_data), .ovf(ovf)
`ifdef COBS_RX_FRAME_ERR_EN
      , .frame_err(frame_err)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int busy_mode = 0;
   int busy_left = 0;
   int ovf_cnt = 0;
   int last_oflag = -1;
   int min_gap = 1000000;
   logic [7:0] sent_q[$], exp_q[$], got_q[$], rx_q[$], seg[$];
   logic [7:0] pay_q[$], pay_all[$], enc_q[$], blk[$];
   int start_cyc_q[$], rx_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (rx_flag) begin
            rx_q.push_back(rx_data);
            rx_cyc_q.push_back(cyc);
         end
         if (ovf) ovf_cnt++;
         if (o_flag) begin
            got_q.push_back(o_data);
            if (last_oflag >= 0 && cyc - last_oflag < min_gap) min_gap = cyc - last_oflag;
            last_oflag = cyc;
         end
      end
   end

   // Consumer model: raises busy one cycle after each o_flag for a random hold time.
   always @(negedge clk) begin
      if (busy_mode == 1) busy = 1'b1;
      else if (busy_mode == 2) begin
         if (busy_left > 0) begin
            busy = 1'b1;
            busy_left--;
         end else busy = 1'b0;
         if (o_flag) busy_left = $urandom_range(1, 6);
      end else busy = 1'b0;
   end

   task automatic clear_state();
      sent_q.delete(); exp_q.delete(); got_q.delete(); rx_q.delete();
      start_cyc_q.delete(); rx_cyc_q.delete();
      ovf_cnt = 0; last_oflag = -1; min_gap = 1000000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      clear_state();
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      @(negedge clk);
      sent_q.push_back(b);
      start_cyc_q.push_back(cyc);
      for (int k = 0; k < 10; k++) begin
         rxd = bits[k];
         repeat (CPB) @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   // Reference: split the stream at delimiters; each frame is a chain of code blocks,
   // and a zero is emitted between blocks unless the earlier block had code 0xFF.
   task automatic build_expected();
      int i, j, code, prev;
      bit first;
      exp_q.delete();
      i = 0;
      while (i < sent_q.size()) begin
         seg.delete();
         while (i < sent_q.size() && sent_q[i] != 8'h00) begin
            seg.push_back(sent_q[i]);
            i++;
         end
         i++;
         j = 0; prev = 0; first = 1'b1;
         while (j < seg.size()) begin
            code = int'(seg[j]);
            if (!first && prev != 255) exp_q.push_back(8'h00);
            for (int k = 1; k < code && j + k < seg.size(); k++) exp_q.push_back(seg[j+k]);
            j += code; prev = code; first = 1'b0;
         end
      end
   endtask

   task automatic cobs_encode();
      enc_q.delete(); blk.delete();
      foreach (pay_q[i]) begin
         if (pay_q[i] == 8'h00) begin
            enc_q.push_back(8'(blk.size() + 1));
            foreach (blk[k]) enc_q.push_back(blk[k]);
            blk.delete();
         end else begin
            blk.push_back(pay_q[i]);
            if (blk.size() == 254) begin
               enc_q.push_back(8'hFF);
               foreach (blk[k]) enc_q.push_back(blk[k]);
               blk.delete();
            end
         end
      end
      enc_q.push_back(8'(blk.size() + 1));
      foreach (blk[k]) enc_q.push_back(blk[k]);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (rx_flag !== 1'b0) begin miscompares++; $display("FAIL reset_rx_flag got %b exp 0", rx_flag); end
      vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
      vectors++; if (o_flag !== 1'b0) begin miscompares++; $display("FAIL reset_o_flag got %b exp 0", o_flag); end
      vectors++; if (o_data !== 8'h00) begin miscompares++; $display("FAIL reset_o_data got %h exp 00", o_data); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      clear_state();
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_uart_bytes();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h55; exp_b[1] = 8'h00; exp_b[2] = 8'hFF;
      do_reset();
      for (int i = 0; i < 3; i++) send_byte(exp_b[i]);
      repeat (20) @(negedge clk);
      vectors++;
      if (rx_q.size() != 3) begin miscompares++; $display("FAIL uart_pulse_count got %0d exp 3", rx_q.size()); end
      for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
         vectors++;
         if (rx_q[i] !== exp_b[i]) begin miscompares++; $display("FAIL uart_byte%0d got %h exp %h", i, rx_q[i], exp_b[i]); end
         vectors++;
         if (rx_cyc_q[i] - start_cyc_q[i] < 77 || rx_cyc_q[i] - start_cyc_q[i] > 81) begin
            miscompares++; $display("FAIL uart_latency%0d got %0d exp 77..81", i, rx_cyc_q[i] - start_cyc_q[i]);
         end
      end
      vectors++; if (rx_data !== 8'hFF) begin miscompares++; $display("FAIL uart_hold got %h exp ff", rx_data); end
      build_expected();
      vectors++;
      if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL uart_decode_count got %0d exp %0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic check_decode(input string name, input int exp_count);
      // Per-scenario tasks call this for the decoded-stream comparison only.
      build_expected();
      vectors++;
      if (got_q.size() != exp_count) begin miscompares++; $display("FAIL %s_count got %0d exp %0d", name, got_q.size(), exp_count); end
      vectors++;
      if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL %s_model_count got %0d exp %0d", name, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL %s_byte%0d got %h exp %h", name, i, got_q[i], exp_q[i]); end
      end
      vectors++;
      if (min_gap < 3) begin miscompares++; $display("FAIL %s_gap got %0d exp >=3", name, min_gap); end
   endtask

   task automatic test_frame();
      logic [7:0] f [7];
      f[0] = 8'h00; f[1] = 8'h03; f[2] = 8'h11; f[3] = 8'h22; f[4] = 8'h02; f[5] = 8'h33; f[6] = 8'h00;
      do_reset();
      busy_mode = 0;
      for (int i = 0; i < 7; i++) send_byte(f[i]);
      repeat (20) @(negedge clk);
      check_decode("frame", 4);
      vectors++;
      if (got_q.size() > 2 && got_q[2] !== 8'h00) begin miscompares++; $display("FAIL frame_implicit_zero got %h exp 00", got_q[2]); end
   endtask

   task automatic test_ff_block();
      do_reset();
      send_byte(8'h00);
      send_byte(8'hFF);
      for (int i = 0; i < 254; i++) send_byte(8'h41);
      send_byte(8'h02);
      send_byte(8'hAA);
      send_byte(8'h00);
      repeat (20) @(negedge clk);
      check_decode("ffblock", 255);
   endtask

   task automatic test_empty_blocks();
      do_reset();
      send_byte(8'h00);
      for (int i = 0; i < 3; i++) send_byte(8'h01);
      send_byte(8'h00);
      repeat (20) @(negedge clk);
      check_decode("empty", 2);
   endtask

   task automatic test_backpressure();
      logic [7:0] f [6];
      f[0] = 8'h05; f[1] = 8'hA1; f[2] = 8'hA2; f[3] = 8'hA3; f[4] = 8'hB4; f[5] = 8'hB5;
      do_reset();
      busy_mode = 1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) send_byte(f[i]);
      repeat (20) @(negedge clk);
      vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL bp_no_output got %0d exp 0", got_q.size()); end
      vectors++; if (ovf_cnt != 2) begin miscompares++; $display("FAIL bp_ovf got %0d exp 2", ovf_cnt); end
      vectors++; if (rx_q.size() != 6) begin miscompares++; $display("FAIL bp_rx_count got %0d exp 6", rx_q.size()); end
      void'(sent_q.pop_back());
      void'(sent_q.pop_back());
      busy_mode = 0;
      repeat (40) @(negedge clk);
      check_decode("bp", 3);
   endtask

   task automatic test_reset_mid_byte();
      logic [9:0] bits;
      do_reset();
      send_byte(8'h02);
      send_byte(8'h33);
      repeat (20) @(negedge clk);
      bits = {1'b1, 8'h5A, 1'b0};
      for (int k = 0; k < 4; k++) begin
         rxd = bits[k];
         repeat (CPB) @(negedge clk);
      end
      rst = 1'b0;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (rx_flag !== 1'b0) begin miscompares++; $display("FAIL mid_rx_flag got %b exp 0", rx_flag); end
      vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL mid_rx_data got %h exp 00", rx_data); end
      vectors++; if (o_flag !== 1'b0) begin miscompares++; $display("FAIL mid_o_flag got %b exp 0", o_flag); end
      vectors++; if (o_data !== 8'h00) begin miscompares++; $display("FAIL mid_o_data got %h exp 00", o_data); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL mid_ovf got %b exp 0", ovf); end
      clear_state();
      rst = 1'b1;
      repeat (20) @(negedge clk);
      send_byte(8'h5A);
      repeat (20) @(negedge clk);
      vectors++; if (rx_q.size() != 1) begin miscompares++; $display("FAIL mid_rx_count got %0d exp 1", rx_q.size()); end
      vectors++;
      if (rx_q.size() > 0 && rx_q[0] !== 8'h5A) begin miscompares++; $display("FAIL mid_rx_byte got %h exp 5a", rx_q[0]); end
      vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL mid_decode got %0d exp 0", got_q.size()); end
   endtask

   task automatic test_random();
      int len;
      do_reset();
      pay_all.delete();
      busy_mode = 2;
      for (int f = 0; f < 5; f++) begin
         pay_q.delete();
         len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++)
            pay_q.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
         foreach (pay_q[i]) pay_all.push_back(pay_q[i]);
         cobs_encode();
         send_byte(8'h00);
         foreach (enc_q[i]) send_byte(enc_q[i]);
      end
      send_byte(8'h00);
      repeat (60) @(negedge clk);
      busy_mode = 0;
      check_decode("random", pay_all.size());
      for (int i = 0; i < pay_all.size() && i < got_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== pay_all[i]) begin miscompares++; $display("FAIL random_payload%0d got %h exp %h", i, got_q[i], pay_all[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_uart_bytes();
      test_frame();
      test_ff_block();
      test_empty_blocks();
      test_backpressure();
      test_reset_mid_byte();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
